// File: rtl/i2c_slave_regif.sv
// Write-only I2C target: matches SLV_ADDR, ACKs each byte and emits one register-write strobe per data byte.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchronizers.
module i2c_slave_regif #(
    parameter logic [6:0]  SLV_ADDR   = 7'h50,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic                  wr_valid,
    output logic [7:0]            wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StReg, StRegAck, StData, StDataAck, StIgnore
    } state_e;

    // Sync flops reset to the idle bus level so leaving reset creates no SDA fall.
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_cur, scl_prev, sda_cur, sda_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], sclk};
            sda_sync_q <= {sda_sync_q[0], sda_in};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] scl_hist_q, sda_hist_q;
    logic [1:0] scl_filt_q, sda_filt_q;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
            scl_filt_q <= 2'b11;
            sda_filt_q <= 2'b11;
        end else begin
            scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
            scl_filt_q <= {scl_filt_q[0], maj3(scl_hist_q)};
            sda_filt_q <= {sda_filt_q[0], maj3(sda_hist_q)};
        end
    end

    assign scl_cur  = scl_filt_q[0];
    assign scl_prev = scl_filt_q[1];
    assign sda_cur  = sda_filt_q[0];
    assign sda_prev = sda_filt_q[1];
`else
    logic scl_d3_q, sda_d3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_d3_q <= 1'b1;
            sda_d3_q <= 1'b1;
        end else begin
            scl_d3_q <= scl_sync_q[1];
            sda_d3_q <= sda_sync_q[1];
        end
    end

    assign scl_cur  = scl_sync_q[1];
    assign scl_prev = scl_d3_q;
    assign sda_cur  = sda_sync_q[1];
    assign sda_prev = sda_d3_q;
`endif

    logic scl_rise, scl_fall, start_cond, stop_cond;
    assign scl_rise   = scl_cur & ~scl_prev;
    assign scl_fall   = ~scl_cur & scl_prev;
    assign start_cond = scl_cur & scl_prev & ~sda_cur & sda_prev;
    assign stop_cond  = scl_cur & scl_prev & sda_cur & ~sda_prev;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [7:0]            ptr_q, ptr_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  busy_q, busy_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [7:0]            wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            shift_q    <= '0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        full_d     = full_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        // Bus conditions outrank any coincident SCL edge and drop partial bytes.
        if (start_cond) begin
            state_d  = StAddr;
            cnt_d    = '0;
            full_d   = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
        end else if (stop_cond) begin
            state_d  = StIdle;
            cnt_d    = '0;
            full_d   = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                StAddr, StReg, StData: begin
                    if (!full_q && scl_rise) begin
                        shift_d = {shift_q[DATA_WIDTH-2:0], sda_cur};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            full_d = 1'b1;
                            if (state_q == StReg) begin
                                ptr_d = shift_d;
                            end else if (state_q == StData) begin
                                wr_valid_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = shift_d;
                                ptr_d      = ptr_q + 8'd1;
                            end
                        end
                    end else if (full_q && scl_fall) begin
                        full_d = 1'b0;
                        cnt_d  = '0;
                        if (state_q == StAddr) begin
                            if (shift_q == {SLV_ADDR, 1'b0}) begin
                                state_d  = StAddrAck;
                                sda_oe_d = 1'b1;
                            end else begin
                                state_d = StIgnore;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            state_d  = (state_q == StReg) ? StRegAck : StDataAck;
                            sda_oe_d = 1'b1;
                        end
                    end
                end
                StAddrAck, StRegAck, StDataAck: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = (state_q == StAddrAck) ? StReg : StData;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Self-checking bench for i2c_slave_regif: bus-level master tasks plus a write-strobe scoreboard.
module tb_i2c_slave_regif;

    localparam int T = 100;  // SCL half period (10 clk)
    localparam int Q = 40;   // SDA setup after SCL fall (4 clk)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_bus;
    logic       sda_oe, wr_valid, busy;
    logic [7:0] wr_addr, wr_data;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [15:0] exp_q[$];
    logic       oe_seen = 1'b0;
    logic       wv_prev = 1'b0;

    assign sda_bus = sda_drv & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_regif dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest pending expected write.
    always @(negedge clk) begin
        if (!rst) begin
            if (sda_oe) oe_seen = 1'b1;
            if (wr_valid) begin
                check("wv_single", {31'd0, wv_prev}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", {31'd0, wr_valid}, 32'd0);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", {24'd0, wr_addr}, {24'd0, e[15:8]});
                    check("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
                end
            end
        end
        wv_prev = wr_valid;
    end

    task automatic i2c_start();
        #Q sda_drv = 1'b1;
        #T scl = 1'b1;
        #T sda_drv = 1'b0;
        #T scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q sda_drv = 1'b0;
        #T scl = 1'b1;
        #T sda_drv = 1'b1;
        #T;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            #Q sda_drv = b[7-i];
            #T scl = 1'b1;
            #T scl = 1'b0;
        end
    endtask

    // exp_ack: 1 = ACK expected, 0 = NACK expected, -1 = not checked.
    task automatic send_byte(input string tag, input logic [7:0] b, input int exp_ack);
        send_bits(b, 8);
        #Q sda_drv = 1'b1;
        #T scl = 1'b1;
        #(T/2);
        @(negedge clk);
        if (exp_ack >= 0) check(tag, {31'd0, sda_oe}, exp_ack);
        #(T/2) scl = 1'b0;
    endtask

    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        wait_clk(4);
        check("rst_sda_oe", {31'd0, sda_oe}, 0);
        check("rst_wr_valid", {31'd0, wr_valid}, 0);
        check("rst_wr_addr", {24'd0, wr_addr}, 0);
        check("rst_wr_data", {24'd0, wr_data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        wait_clk(10);

        // Single write
        i2c_start();
        wait_clk(2);
        check("busy_start", {31'd0, busy}, 1);
        send_byte("ack_addr", 8'hA0, 1);
        send_byte("ack_reg", 8'h12, 1);
        exp_q.push_back({8'h12, 8'h5A});
        send_byte("ack_data", 8'h5A, 1);
        i2c_stop();
        wait_clk(10);
        check("busy_stop", {31'd0, busy}, 0);

        // Address mismatch
        oe_seen = 1'b0;
        i2c_start();
        send_byte("nack_a2", 8'hA2, 0);
        check("busy_mismatch", {31'd0, busy}, 0);
        send_byte("nack_reg", 8'h34, 0);
        send_byte("nack_data", 8'h56, 0);
        i2c_stop();
        wait_clk(10);
        check("oe_never", {31'd0, oe_seen}, 0);

        // Read request is rejected
        i2c_start();
        send_byte("nack_read", 8'hA1, 0);
        send_byte("nack_rd_b", 8'h77, 0);
        i2c_stop();
        wait_clk(10);
        check("busy_read", {31'd0, busy}, 0);

        // Burst with pointer wrap
        i2c_start();
        send_byte("ack_addr2", 8'hA0, 1);
        send_byte("ack_reg_ff", 8'hFF, 1);
        exp_q.push_back({8'hFF, 8'h11});
        send_byte("ack_d11", 8'h11, 1);
        exp_q.push_back({8'h00, 8'h22});
        send_byte("ack_d22", 8'h22, 1);
        i2c_stop();
        wait_clk(10);

        // Partial bytes cut by STOP and by repeated START
        i2c_start();
        send_byte("ack_addr3", 8'hA0, 1);
        send_byte("ack_reg20", 8'h20, 1);
        send_bits(8'hC3, 4);
        i2c_stop();
        wait_clk(10);
        i2c_start();
        send_byte("ack_addr4", 8'hA0, 1);
        send_byte("ack_reg30", 8'h30, 1);
        send_bits(8'h3C, 4);
        i2c_start();
        send_byte("ack_addr5", 8'hA0, 1);
        send_byte("ack_reg40", 8'h40, 1);
        exp_q.push_back({8'h40, 8'h77});
        send_byte("ack_d77", 8'h77, 1);
        i2c_stop();
        wait_clk(10);

        // Reset during DATA_ACK
        i2c_start();
        send_byte("ack_addr6", 8'hA0, 1);
        send_byte("ack_reg60", 8'h60, 1);
        exp_q.push_back({8'h60, 8'h99});
        send_bits(8'h99, 8);
        sda_drv = 1'b1;
        wait_clk(8);
        check("oe_dack", {31'd0, sda_oe}, 1);
        rst = 1'b1;
        @(negedge clk);
        check("oe_after_rst", {31'd0, sda_oe}, 0);
        check("busy_after_rst", {31'd0, busy}, 0);
        check("addr_after_rst", {24'd0, wr_addr}, 0);
        rst = 1'b0;
        #T scl = 1'b1;
        #T scl = 1'b0;
        i2c_stop();
        wait_clk(10);

        // Normal operation after reset
        i2c_start();
        send_byte("ack_addr7", 8'hA0, 1);
        send_byte("ack_reg07", 8'h07, 1);
        exp_q.push_back({8'h07, 8'hC3});
        send_byte("ack_dc3", 8'hC3, 1);
        i2c_stop();
        wait_clk(10);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // One-cycle SCL glitch must not add a bit
        i2c_start();
        send_byte("ack_addr8", 8'hA0, 1);
        send_byte("ack_reg50", 8'h50, 1);
        @(negedge clk);
        scl = 1'b1;
        @(negedge clk);
        scl = 1'b0;
        exp_q.push_back({8'h50, 8'h66});
        send_byte("ack_d66", 8'h66, 1);
        i2c_stop();
        wait_clk(10);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
